// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter: NREQ producers share one data register, with an
// optional forced idle gap after every accepted write.
module reg_wr_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          DWIDTH    = 8,
  parameter logic [63:0] POR_VALUE = '0,
  parameter int          GAP       = 0,
  localparam int         SW        = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic [DWIDTH-1:0]        out,
  output logic                     out_vld,
  output logic [SW-1:0]            out_src,
  output logic                     busy
);

  logic [DWIDTH-1:0] dw [NREQ];
  logic [SW-1:0]     ptr, win, ptr_nxt;
  logic [SW:0]       sum;
  logic [7:0]        gap_cnt;
  logic              accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign dw[i] = data[i*DWIDTH +: DWIDTH];
  end

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    win = '0;
    sum = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (SW+1)'(k);
      if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
      if (req[sum[SW-1:0]]) win = sum[SW-1:0];
    end
  end

  assign busy    = |gap_cnt;
  assign accept  = rst_n && !busy && |req;
  assign ptr_nxt = (win == SW'(NREQ-1)) ? '0 : win + 1'b1;

  always_comb begin
    gnt = '0;
    if (accept) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out     <= POR_VALUE[DWIDTH-1:0];
      out_vld <= 1'b0;
      out_src <= '0;
      ptr     <= '0;
      gap_cnt <= '0;
    end else if (accept) begin
      out     <= dw[win];
      out_src <= win;
      out_vld <= 1'b1;
      ptr     <= ptr_nxt;
      gap_cnt <= 8'(GAP);
    end else begin
      out_vld <= 1'b0;
      if (busy) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench: three arbiter configs (4/gap0, 4/gap2, 3/gap0) against a
// queue-based reference model of the round-robin write rules.
module tb_reg_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] rq [3];
  logic [7:0] dd [3][4];

  logic [3:0]  r0, r1;
  logic [2:0]  r2;
  logic [31:0] d0, d1;
  logic [23:0] d2;
  logic [3:0]  g0, g1;
  logic [2:0]  g2;
  logic [7:0]  o0, o1, o2;
  logic        v0, v1, v2, b0, b1, b2;
  logic [1:0]  s0, s1, s2;

  assign r0 = rq[0];
  assign r1 = rq[1];
  assign r2 = rq[2][2:0];
  assign d0 = {dd[0][3], dd[0][2], dd[0][1], dd[0][0]};
  assign d1 = {dd[1][3], dd[1][2], dd[1][1], dd[1][0]};
  assign d2 = {dd[2][2], dd[2][1], dd[2][0]};

  reg_wr_arbiter #(.NREQ(4), .DWIDTH(8), .POR_VALUE(64'h5A), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(r0), .data(d0), .gnt(g0),
    .out(o0), .out_vld(v0), .out_src(s0), .busy(b0));
  reg_wr_arbiter #(.NREQ(4), .DWIDTH(8), .POR_VALUE(64'h5A), .GAP(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req(r1), .data(d1), .gnt(g1),
    .out(o1), .out_vld(v1), .out_src(s1), .busy(b1));
  reg_wr_arbiter #(.NREQ(3), .DWIDTH(8), .POR_VALUE(64'h5A), .GAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req(r2), .data(d2), .gnt(g2),
    .out(o2), .out_vld(v2), .out_src(s2), .busy(b2));

  logic [3:0] ga [3];
  logic [7:0] oa [3];
  logic [1:0] sa [3];
  logic       va [3], ba [3];
  assign ga[0] = g0;  assign ga[1] = g1;  assign ga[2] = {1'b0, g2};
  assign oa[0] = o0;  assign oa[1] = o1;  assign oa[2] = o2;
  assign sa[0] = s0;  assign sa[1] = s1;  assign sa[2] = s2;
  assign va[0] = v0;  assign va[1] = v1;  assign va[2] = v2;
  assign ba[0] = b0;  assign ba[1] = b1;  assign ba[2] = b2;

  localparam int NR [3]        = '{4, 4, 3};
  localparam int GP [3]        = '{0, 2, 0};
  localparam logic [3:0] MSK [3] = '{4'hF, 4'hF, 4'h7};

  int cmp = 0, bad = 0;
  bit started = 0;

  // Reference model: state as it will be after the next rising edge.
  int         mptr [3], mgap [3], msrc [3];
  logic [7:0] mout [3];
  bit         mvld [3];
  int         sbq  [3][$];

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, u, $time, act, exp);
    end
  endtask

  function automatic int pick(input int u);
    for (int k = 0; k < NR[u]; k++) begin
      int i;
      i = (mptr[u] + k) % NR[u];
      if (rq[u][i]) return i;
    end
    return -1;
  endfunction

  int         w;
  bit         acc;
  logic [3:0] eg;

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      w   = pick(u);
      acc = rst_n && (mgap[u] == 0) && (w >= 0);
      eg  = acc ? 4'(1 << w) : 4'd0;
      if (started || !rst_n) chk("gnt", u, 32'(ga[u]), 32'(eg));
      if (started) begin
        chk("busy",    u, 32'(ba[u]), 32'(mgap[u] != 0));
        chk("out_vld", u, 32'(va[u]), 32'(mvld[u]));
        chk("out",     u, 32'(oa[u]), 32'(mout[u]));
        chk("out_src", u, 32'(sa[u]), 32'(msrc[u]));
      end
      if (!rst_n) begin
        mptr[u] = 0; mgap[u] = 0; mout[u] = 8'h5A; mvld[u] = 0; msrc[u] = 0;
        sbq[u].delete();
      end else if (acc) begin
        mout[u] = dd[u][w];
        msrc[u] = w;
        mvld[u] = 1;
        mptr[u] = (w + 1) % NR[u];
        mgap[u] = GP[u];
        sbq[u].push_back((w << 8) | int'(dd[u][w]));
      end else begin
        mvld[u] = 0;
        if (mgap[u] != 0) mgap[u]--;
      end
    end
    if (!rst_n) started = 1;
  end

  // Monitor: every out_vld must match the oldest outstanding accepted write.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (started && va[u] === 1'b1) begin
        if (sbq[u].size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL sb_underflow dut%0d t=%0t: out_vld with no write outstanding", u, $time);
        end else begin
          int e;
          e = sbq[u].pop_front();
          chk("sb_data", u, 32'(oa[u]), 32'(e & 255));
          chk("sb_src",  u, 32'(sa[u]), 32'(e >> 8));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] v);
    for (int u = 0; u < 3; u++) rq[u] = v & MSK[u];
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(4'hF);
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 4; i++) dd[u][i] = 8'(8'h10 + i);
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    set_req(4'b0100); cyc();
    set_req(4'b1001); cyc(); cyc();
    set_req(4'b0000); cyc(); cyc();
    set_req(4'hF); repeat (2) cyc();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; repeat (4) cyc();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      for (int u = 0; u < 3; u++) begin
        if ($urandom_range(0, 3) == 0) rq[u] = 4'($urandom) & MSK[u];
        for (int i = 0; i < 4; i++) dd[u][i] = 8'($urandom);
      end
      cyc();
    end
    rst_n = 1'b1;
    set_req(4'h0);
    repeat (5) cyc();
    @(negedge clk); #1;
    for (int u = 0; u < 3; u++) chk("sb_drain", u, 32'(sbq[u].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Round-robin write arbiter that shares one enabled data register among NREQ requesters.
- Each requester presents a request and a data word. One winner per accept cycle is granted, and its data is loaded into the shared register.
- Used wherever several producers update one configuration/status register.
- An optional minimum gap between consecutive writes is enforced by an internal counter.

Parameters:
- NREQ, 4, number of requesters; legal values 2..16.
- DWIDTH, 8, data/register width in bits.
- POR_VALUE, 0, reset value of the shared register; only bits [DWIDTH-1:0] are used.
- GAP, 0, idle cycles forced after every accepted write; legal values 0..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- req  in  NREQ  per-requester write request; held until granted.
- data  in  NREQ*DWIDTH  flattened write data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- gnt  out  NREQ  one-hot grant, combinational, asserted in the accept cycle.
- out  out  DWIDTH  shared register value.
- out_vld  out  1  registered; high in the cycle after each accept, i.e. the first cycle out shows new data.
- out_src  out  max(1,$clog2(NREQ))  registered index of the last writer.
- busy  out  1  high while the gap counter is non-zero.

Behaviour:
- State:
  - ptr: round-robin priority pointer, range 0..NREQ-1.
  - gap_cnt: 8 bits.
  - register out, plus out_vld and out_src.
- Reset (rst_n low at a rising edge):
  - out = POR_VALUE[DWIDTH-1:0], out_vld = 0, out_src = 0, ptr = 0, gap_cnt = 0.
  - gnt is forced to 0 combinationally while rst_n = 0, regardless of req.
- Accept condition: rst_n = 1 and gap_cnt == 0 and req != 0.
- Winner selection: first i with req[i] = 1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - gnt[winner] = 1; all other gnt bits = 0.
  - With no accept, gnt = 0.
- On the accept edge:
  - out <= data[winner], out_src <= winner, out_vld <= 1.
  - ptr <= winner+1, wrapping NREQ-1 -> 0; non-power-of-2 NREQ must wrap correctly.
  - gap_cnt <= GAP.
- Edge without accept:
  - out and out_src hold; out_vld <= 0.
  - gap_cnt <= gap_cnt-1 if non-zero.
  - ptr holds.
- busy = (gap_cnt != 0), taken combinationally from the register.
- Latency: data is visible on out one cycle after gnt.
- Throughput: GAP = 0 gives one write per cycle, with out_vld continuously high under constant requests. GAP = G gives one write every G+1 cycles.
- Requester protocol:
  - A requester may drop req before being granted; it then gets no grant and no write occurs for it.
  - data is sampled only in the gnt cycle.
  - A requester keeping req high after its grant is re-arbitrated and gets lowest priority next.
- Fairness: with all requests held constant, each requester is granted exactly once per NREQ accepts.
- Reset mid-gap: reset dominates. Counter cleared, pointer reset, out restored; the next cycle may accept.
- No X propagation: out changes only on reset or accept.

Test Plan:
Common settings: NREQ=4, DWIDTH=8, POR_VALUE=8'h5A, GAP=0 unless noted.

1. Reset: rst_n low 2 cycles with req=4'hF -> gnt=0, out=8'h5A, out_vld=0, out_src=0. After release, first gnt=4'b0001.
2. Full load: req=4'hF constant, data[i]=8'h10+i -> gnt 0001,0010,0100,1000,0001. out 10,11,12,13,10, each one cycle after its gnt. out_vld stays high; out_src follows 0,1,2,3,0.
3. Pointer order:
   - req=4'b0100 alone -> gnt=0100, ptr=3.
   - Next cycle req=4'b1001 -> gnt=1000, then 0001.
   - Then req=0 -> gnt=0, out_vld falls, out holds 8'h..
4. Gap (GAP=2): req=4'hF constant -> grants on cycles 0,3,6. busy high in cycles 1-2 and 4-5. out_vld is a single-cycle pulse in cycles 1,4,7.
5. Reset mid-gap (GAP=2): rst_n low for 1 cycle while gap_cnt=1 -> next cycle busy=0, out=8'h5A, out_vld=0. Next accept goes to the lowest-index requesting input (ptr=0).
6. NREQ=3 wrap: req=3'b111 -> gnt 001,010,100,001. out_src wraps 2 -> 0 and never shows 3.
